// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and parity modes.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic [1:0] NONE = 2'd0;
  localparam logic [1:0] ODD  = 2'd1;
  localparam logic [1:0] EVEN = 2'd2;

  // Parity bit that makes the frame correct, given the XOR of the data bits.
  function automatic logic parity_bit(input logic [1:0] mode, input logic data_xor);
    return (mode == ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to idle-high.
module rx_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/rx.sv
// Oversampling UART receiver: start-edge detect, mid-bit sampling, parity and
// stop-bit checking, one-cycle rx_done with data and error flags.
module rx
  import uart_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int stop_bit   = 2,
  parameter int test       = 2,
  parameter int OVERSAMPLE = 16
) (
  input  logic             rx_clk,
  input  logic             rx_rst_n,
  input  logic             rx_data_in,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_done,
  output logic             rx_parity_err,
  output logic             rx_frame_err,
  output logic [2:0]       rx_state_o
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] HALF      = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL      = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(stop_bit - 1);
  localparam logic [1:0]    MODE      = 2'(test);
  localparam logic          HAS_PAR   = (MODE == ODD) || (MODE == EVEN);

  logic             line;
  logic             line_prev_q;
  uart_state_e      state_q;
  logic [CW-1:0]    samp_q;
  logic [BW-1:0]    bit_q;
  logic [WIDTH-1:0] shift_q;
  logic             par_err_q;
  logic             frm_err_q;
  logic [WIDTH-1:0] data_q;
  logic             done_q;
  logic             pe_q;
  logic             fe_q;

  rx_sync u_sync (
    .clk_i  (rx_clk),
    .rst_ni (rx_rst_n),
    .d_i    (rx_data_in),
    .q_o    (line)
  );

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      line_prev_q <= 1'b1;
      state_q     <= ST_IDLE;
      samp_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      par_err_q   <= 1'b0;
      frm_err_q   <= 1'b0;
      data_q      <= '0;
      done_q      <= 1'b0;
      pe_q        <= 1'b0;
      fe_q        <= 1'b0;
    end else begin
      line_prev_q <= line;
      done_q      <= 1'b0;
      case (state_q)
        // A falling edge needs a high sample first, so a stuck-low line never re-arms.
        ST_IDLE: begin
          if (line_prev_q && !line) begin
            state_q <= ST_START;
            samp_q  <= '0;
          end
        end
        ST_START: begin
          if (samp_q == HALF) begin
            samp_q <= '0;
            if (!line) begin
              state_q   <= ST_DATA;
              bit_q     <= '0;
              par_err_q <= 1'b0;
              frm_err_q <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            samp_q <= samp_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (samp_q == FULL) begin
            samp_q  <= '0;
            shift_q <= {line, shift_q[WIDTH-1:1]};
            if (bit_q == LAST_DATA) begin
              bit_q   <= '0;
              state_q <= HAS_PAR ? ST_PARITY : ST_STOP;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            samp_q <= samp_q + 1'b1;
          end
        end
        ST_PARITY: begin
          if (samp_q == FULL) begin
            samp_q    <= '0;
            par_err_q <= (line != parity_bit(MODE, ^shift_q));
            state_q   <= ST_STOP;
          end else begin
            samp_q <= samp_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (samp_q == FULL) begin
            samp_q    <= '0;
            frm_err_q <= frm_err_q | ~line;
            if (bit_q == LAST_STOP) begin
              // Back to IDLE at the stop centre so a gapless next start is caught.
              state_q <= ST_IDLE;
              bit_q   <= '0;
              done_q  <= 1'b1;
              data_q  <= shift_q;
              pe_q    <= par_err_q;
              fe_q    <= frm_err_q | ~line;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            samp_q <= samp_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rx_data       = data_q;
  assign rx_done       = done_q;
  assign rx_parity_err = pe_q;
  assign rx_frame_err  = fe_q;
  assign rx_state_o    = state_q;

endmodule

// File: tb/tb_rx.sv
// Bench for rx: three instances (parity none/odd/even) fed serial frames; expected
// words go into per-instance queues and a monitor compares them on every rx_done.
module tb_rx;

  localparam int W  = 8;
  localparam int OS = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   line_v;
  logic [W-1:0] data_v [3];
  logic [2:0]   done_v;
  logic [2:0]   pe_v;
  logic [2:0]   fe_v;
  logic [2:0]   st_v [3];

  int n_checks = 0;
  int n_fail   = 0;

  // Expected word layout: {data, parity_err, frame_err}
  logic [W+1:0] exp_q0[$];
  logic [W+1:0] exp_q1[$];
  logic [W+1:0] exp_q2[$];
  logic [W-1:0] last_data [3];

  always #5 clk = ~clk;

  rx #(.WIDTH(W), .stop_bit(2), .test(0), .OVERSAMPLE(OS)) u_rx0 (
    .rx_clk(clk), .rx_rst_n(rst_n), .rx_data_in(line_v[0]), .rx_data(data_v[0]),
    .rx_done(done_v[0]), .rx_parity_err(pe_v[0]), .rx_frame_err(fe_v[0]), .rx_state_o(st_v[0]));
  rx #(.WIDTH(W), .stop_bit(2), .test(1), .OVERSAMPLE(OS)) u_rx1 (
    .rx_clk(clk), .rx_rst_n(rst_n), .rx_data_in(line_v[1]), .rx_data(data_v[1]),
    .rx_done(done_v[1]), .rx_parity_err(pe_v[1]), .rx_frame_err(fe_v[1]), .rx_state_o(st_v[1]));
  rx #(.WIDTH(W), .stop_bit(2), .test(2), .OVERSAMPLE(OS)) u_rx2 (
    .rx_clk(clk), .rx_rst_n(rst_n), .rx_data_in(line_v[2]), .rx_data(data_v[2]),
    .rx_done(done_v[2]), .rx_parity_err(pe_v[2]), .rx_frame_err(fe_v[2]), .rx_state_o(st_v[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int inst, input logic [W+1:0] v);
    case (inst)
      0:       exp_q0.push_back(v);
      1:       exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endtask

  function automatic int q_size(input int inst);
    case (inst)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  task automatic pop_exp(input int inst, output logic [W+1:0] v);
    case (inst)
      0:       v = exp_q0.pop_front();
      1:       v = exp_q1.pop_front();
      default: v = exp_q2.pop_front();
    endcase
  endtask

  task automatic monitor();
    logic [2:0]   prev_done = '0;
    logic [W+1:0] e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (done_v[i]) begin
          chk($sformatf("done_single_cycle%0d", i), 32'(prev_done[i]), 32'd0);
          chk($sformatf("done_expected%0d", i), 32'(q_size(i) != 0), 32'd1);
          if (q_size(i) != 0) begin
            pop_exp(i, e);
            chk($sformatf("rx_data%0d", i), 32'(data_v[i]), 32'(e[W+1:2]));
            chk($sformatf("parity_err%0d", i), 32'(pe_v[i]), 32'(e[1]));
            chk($sformatf("frame_err%0d", i), 32'(fe_v[i]), 32'(e[0]));
          end
        end
      end
      prev_done = done_v;
    end
  endtask

  task automatic drive_bit(input int inst, input logic v);
    line_v[inst] = v;
    repeat (OS) @(negedge clk);
  endtask

  // Instance index doubles as parity mode: 0 none, 1 odd, 2 even.
  task automatic send_frame(input int inst, input logic [W-1:0] d, input logic flip_par,
                            input logic [1:0] stops, input int gap);
    int   ones;
    logic pbit;
    logic pe;
    logic fe;
    ones = $countones(d);
    pbit = (inst == 1) ? logic'((ones % 2) == 0) : logic'((ones % 2) == 1);
    pbit = pbit ^ flip_par;
    pe   = (inst == 0) ? 1'b0 : logic'((((ones + int'(pbit)) % 2) == 1) != (inst == 1));
    fe   = !(stops[0] && stops[1]);
    push_exp(inst, {d, pe, fe});
    last_data[inst] = d;
    drive_bit(inst, 1'b0);
    for (int i = 0; i < W; i++) drive_bit(inst, d[i]);
    if (inst != 0) drive_bit(inst, pbit);
    drive_bit(inst, stops[0]);
    drive_bit(inst, stops[1]);
    line_v[inst] = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] d;
    logic [1:0]   s;
    int           inst;
    int           gap;
    rst_n  = 1'b0;
    line_v = 3'b111;
    for (int i = 0; i < 3; i++) last_data[i] = '0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_data%0d", i), 32'(data_v[i]), 32'd0);
      chk($sformatf("reset_done%0d", i), 32'(done_v[i]), 32'd0);
      chk($sformatf("reset_perr%0d", i), 32'(pe_v[i]), 32'd0);
      chk($sformatf("reset_ferr%0d", i), 32'(fe_v[i]), 32'd0);
      chk($sformatf("reset_state%0d", i), 32'(st_v[i]), 32'd0);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    fork
      monitor();
    join_none

    send_frame(2, 8'hA5, 1'b0, 2'b11, 20);
    send_frame(1, 8'h3C, 1'b1, 2'b11, 20);

    // Short low glitch must be rejected as a false start.
    line_v[2] = 1'b0;
    repeat (4) @(negedge clk);
    line_v[2] = 1'b1;
    repeat (30) @(negedge clk);
    chk("false_start_state", 32'(st_v[2]), 32'd0);
    chk("false_start_data", 32'(data_v[2]), 32'(last_data[2]));

    send_frame(0, 8'h55, 1'b0, 2'b01, 20);
    send_frame(0, 8'h0F, 1'b0, 2'b11, 20);

    send_frame(2, 8'h01, 1'b0, 2'b11, 0);
    send_frame(2, 8'hFF, 1'b0, 2'b11, 0);
    send_frame(2, 8'h80, 1'b0, 2'b11, 20);

    // Reset in the middle of data bit 3 of 0x99 (a high bit, so no edge at release).
    drive_bit(2, 1'b0);
    drive_bit(2, 1'b1);
    drive_bit(2, 1'b0);
    drive_bit(2, 1'b0);
    line_v[2] = 1'b1;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) last_data[i] = '0;
    chk("midreset_data", 32'(data_v[2]), 32'd0);
    chk("midreset_state", 32'(st_v[2]), 32'd0);
    repeat (40) @(negedge clk);
    send_frame(2, 8'h12, 1'b0, 2'b11, 20);

    for (int k = 0; k < 36; k++) begin
      inst = $urandom_range(0, 2);
      d    = W'($urandom);
      s    = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      gap  = s[1] ? $urandom_range(0, 30) : $urandom_range(4, 30);
      send_frame(inst, d, logic'($urandom_range(0, 3) == 0), s, gap);
    end

    for (int t = 0; t < 200 && (q_size(0) + q_size(1) + q_size(2)) != 0; t++) @(negedge clk);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("queue_drained%0d", i), 32'(q_size(i)), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx.md
RX -- requirements
Module: rx

Interface
REQ-001 Parameter WIDTH, default 8, number of data bits per frame.
REQ-002 Parameter stop_bit, default 2, number of stop bits per frame (1 or 2).
REQ-003 Parameter test, default 2, parity mode: 0 none, 1 odd, 2 even, 3 treated as none.
REQ-004 Parameter OVERSAMPLE, default 16, rx_clk cycles per bit period (even, >=4).
REQ-005 Clocking SHALL be one clock; reset is asynchronous and active-low (rx_clk, rx_rst_n).
REQ-006 rx_clk  input  1  sampling clock, OVERSAMPLE x baud.
REQ-007 rx_rst_n  input  1  asynchronous active-low reset.
REQ-008 rx_data_in  input  1  serial line; idle high; asynchronous to rx_clk.
REQ-009 rx_data  output  WIDTH  last received data word.
REQ-010 rx_done  output  1  one-cycle pulse: frame complete, rx_data and error flags valid.
REQ-011 rx_parity_err  output  1  parity mismatch for the frame flagged by rx_done.
REQ-012 rx_frame_err  output  1  any stop bit sampled low in the frame flagged by rx_done.

Function
REQ-013 rx_data_in SHALL pass through a 2-flop synchronizer before any use; all timing below is relative to the synchronized line.
REQ-014 Frame format SHALL be: start bit 0, WIDTH data bits LSB first, parity bit only when test is 1 or 2, stop_bit stop bits of 1.
REQ-015 States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE: a high-to-low transition on the synchronized line SHALL enter START and clear the sample counter.
REQ-017 START: at sample count OVERSAMPLE/2-1 (mid-bit) the line SHALL be checked; low -> DATA with counter restarted; high -> false start, return to IDLE, no rx_done.
REQ-018 DATA/PARITY/STOP: each bit SHALL be sampled once when the counter reaches OVERSAMPLE-1 after the previous mid-sample, i.e. at every bit centre.
REQ-019 DATA SHALL shift samples into a WIDTH-bit register LSB first; after the WIDTH-th bit -> PARITY if test is 1 or 2, else STOP.
REQ-020 PARITY: expected bit SHALL be ~^data for odd (1) and ^data for even (2); mismatch sets internal parity error.
REQ-021 STOP: each of stop_bit stop bits sampled; any low sample sets internal frame error; after the last stop-bit sample -> IDLE.
REQ-022 On the cycle after the last stop-bit mid-sample, rx_done SHALL pulse high for exactly one cycle while rx_data, rx_parity_err and rx_frame_err update together.
REQ-023 rx_data and the error flags SHALL hold until the next rx_done; with test 0 or 3 rx_parity_err SHALL be 0.
REQ-024 Return to IDLE at the last stop-bit centre SHALL allow a start edge arriving half a bit later to be caught (back-to-back frames with no idle gap).
REQ-025 A frame with frame error SHALL still deliver rx_done and rx_data; if the line remains low, IDLE SHALL wait for high before arming a new start edge.
REQ-026 Bit counter SHALL be sized clog2(WIDTH+1); sample counter clog2(OVERSAMPLE); no wrap before its terminal count.

Reset
REQ-027 Reset SHALL force state IDLE, counters 0, rx_data 0, rx_done 0, rx_parity_err 0, rx_frame_err 0, synchronizer flops 1.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; no rx_done is produced for it after release.

Structure
REQ-029 State encodings and parity-mode constants (NONE, ODD, EVEN) SHALL live in shared package uart_pkg, used by this block and the transmitter.
REQ-030 The 2-flop synchronizer SHALL be a sub-module named rx_sync; everything else is in rx.

Verification (WIDTH 8, stop_bit 2, OVERSAMPLE 16 unless noted)
REQ-031 test 2, frame 0xA5 with parity 0 -> one rx_done, rx_data 0xA5, rx_parity_err 0, rx_frame_err 0.
REQ-032 test 1, frame 0x3C with parity bit forced 0 -> rx_done, rx_data 0x3C, rx_parity_err 1.
REQ-033 line low for 4 cycles then high -> no rx_done, state back in IDLE, rx_data unchanged.
REQ-034 test 0, frame 0x55 with second stop bit 0 -> rx_done, rx_data 0x55, rx_frame_err 1; line then high, next frame 0x0F received clean.
REQ-035 test 2, frames 0x01, 0xFF, 0x80 sent back-to-back with no idle gap -> three rx_done pulses, data in order, no errors.
REQ-036 rx_rst_n pulsed low during data bit 3 of 0x99, then a full frame 0x12 -> single rx_done with 0x12.
